// File: rtl/peak_detector_pkg.sv
// Shared settings and types for the peak detector: sample/timestamp widths,
// holdoff and FIFO sizing, FSM state encoding and the event payload layout.
package peak_detector_pkg;

  localparam int unsigned SIZE_FILTER_DATA = 16;
  localparam int unsigned SIZE_TIMESTAMP   = 32;
  localparam int unsigned SIZE_PEAK_WIDTH  = 8;
  localparam int unsigned PEAK_HOLDOFF     = 8;
  localparam int unsigned PEAK_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    PD_IDLE    = 2'd0,
    PD_ARMED   = 2'd1,
    PD_HOLDOFF = 2'd2
  } peak_state_t;

  // Event layout at the default widths; "time" is reserved, hence peak_time.
  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amplitude;
    logic [SIZE_TIMESTAMP-1:0]          peak_time;
    logic [SIZE_PEAK_WIDTH-1:0]         width;
  } peak_event_t;

endpackage

// File: rtl/peak_event_fifo.sv
// Synchronous event FIFO with a registered head/valid; a pop and a push may
// share a cycle even when full.
module peak_event_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic         full_c,
  output logic         valid,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [W-1:0]     head_next;
  logic             do_push;
  logic             do_pop;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign do_pop     = valid && pop;
  assign do_push    = push && (!full_c || do_pop);
  assign rd_next    = rd_ptr + PTR_W'(do_pop);
  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);

  // Next head: the incoming entry when it lands at the new read slot.
  always_comb begin
    head_next = mem[rd_next];
    if (do_push && (rd_next == wr_ptr)) head_next = data;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      head   <= (count_next != '0) ? head_next : '0;
    end
  end

endmodule

// File: rtl/peak_detector.sv
// Extracts one {peak amplitude, peak timestamp, width} event per pulse above
// threshold and queues it for a valid/ready consumer.
module peak_detector
  import peak_detector_pkg::*;
#(
  parameter int unsigned DATA_W     = SIZE_FILTER_DATA,
  parameter int unsigned TS_W       = SIZE_TIMESTAMP,
  parameter int unsigned WIDTH_W    = SIZE_PEAK_WIDTH,
  parameter int unsigned HOLDOFF    = PEAK_HOLDOFF,
  parameter int unsigned FIFO_DEPTH = PEAK_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_amplitude,
  output logic [TS_W-1:0]          out_time,
  output logic [WIDTH_W-1:0]       out_width,
  output logic [15:0]              drop_count,
  output logic                     busy
);

  localparam int unsigned EVENT_W = DATA_W + TS_W + WIDTH_W;
  localparam int unsigned HCNT_W  = 8;

  peak_state_t              state;
  peak_state_t              state_next;
  logic [TS_W-1:0]          ts;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] max_next;
  logic [TS_W-1:0]          tmax_q;
  logic [TS_W-1:0]          tmax_next;
  logic [WIDTH_W-1:0]       width_q;
  logic [WIDTH_W-1:0]       width_next;
  logic [HCNT_W-1:0]        hcnt_q;
  logic [HCNT_W-1:0]        hcnt_next;
  logic                     above;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic [EVENT_W-1:0]       head;

  assign above = (input_data > threshold);
  assign pop   = out_valid && out_ready;

  always_comb begin
    state_next = state;
    max_next   = max_q;
    tmax_next  = tmax_q;
    width_next = width_q;
    hcnt_next  = hcnt_q;
    push       = 1'b0;
    unique case (state)
      PD_IDLE: begin
        if (above) begin
          state_next = PD_ARMED;
          max_next   = input_data;
          tmax_next  = ts;
          width_next = WIDTH_W'(1);
        end
      end
      PD_ARMED: begin
        if (above) begin
          if (width_q != '1) width_next = width_q + WIDTH_W'(1);
          // Strict compare: on a tie the earlier sample stays the peak.
          if (input_data > max_q) begin
            max_next  = input_data;
            tmax_next = ts;
          end
        end else begin
          push       = 1'b1;
          state_next = PD_HOLDOFF;
          hcnt_next  = HCNT_W'(HOLDOFF - 1);
        end
      end
      PD_HOLDOFF: begin
        if (hcnt_q == '0) state_next = PD_IDLE;
        else              hcnt_next  = hcnt_q - HCNT_W'(1);
      end
      default: state_next = PD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= PD_IDLE;
      ts         <= '0;
      max_q      <= '0;
      tmax_q     <= '0;
      width_q    <= '0;
      hcnt_q     <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
    end else begin
      state   <= state_next;
      ts      <= ts + TS_W'(1);
      max_q   <= max_next;
      tmax_q  <= tmax_next;
      width_q <= width_next;
      hcnt_q  <= hcnt_next;
      busy    <= (state_next != PD_IDLE);
      if (push && fifo_full && !pop && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  peak_event_fifo #(
    .W     (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .data   ({max_q, tmax_q, width_q}),
    .pop    (out_ready),
    .full_c (fifo_full),
    .valid  (out_valid),
    .head   (head)
  );

  assign out_amplitude = head[EVENT_W-1 -: DATA_W];
  assign out_time      = head[WIDTH_W +: TS_W];
  assign out_width     = head[WIDTH_W-1:0];

endmodule

// File: tb/tb_peak_detector.sv
// Scoreboard bench for peak_detector: a pulse-level reference model queues
// expected events, a monitor checks every handshake transfer.
module tb_peak_detector;
  import peak_detector_pkg::*;

  localparam int unsigned DATA_W  = SIZE_FILTER_DATA;
  localparam int unsigned TS_W    = 8;
  localparam int unsigned WIDTH_W = SIZE_PEAK_WIDTH;
  localparam int          HOLD    = 8;
  localparam int          DEPTH   = 4;
  localparam int          TS_MOD  = 256;
  localparam int          WMAX    = 255;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [DATA_W-1:0] input_data = '0;
  logic signed [DATA_W-1:0] threshold = '0;
  logic                     out_ready = 1'b0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_amplitude;
  logic [TS_W-1:0]          out_time;
  logic [WIDTH_W-1:0]       out_width;
  logic [15:0]              drop_count;
  logic                     busy;

  typedef struct {
    int amp;
    int t;
    int w;
  } ev_t;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];
  bit  done = 1'b0;

  always #5 clk = ~clk;

  peak_detector #(
    .DATA_W     (DATA_W),
    .TS_W       (TS_W),
    .WIDTH_W    (WIDTH_W),
    .HOLDOFF    (HOLD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .input_data    (input_data),
    .threshold     (threshold),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_amplitude (out_amplitude),
    .out_time      (out_time),
    .out_width     (out_width),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pulses are collected as sample lists and reduced when
  // they end; the FIFO is an occupancy count plus the expected-event queue.
  bit  started = 1'b0;
  bit  just_reset = 1'b0;
  int  m_ts = 0;
  bit  in_pulse = 1'b0;
  int  dead_left = 0;
  int  p_amp[$];
  int  p_ts[$];
  int  occ = 0;
  int  drops = 0;
  bit  m_above;
  bit  m_pop;
  bit  m_push;
  ev_t m_ev;

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, occ > 0);
      check("busy", busy, in_pulse || (dead_left > 0));
      check("drop_count", drop_count, drops);
      if (just_reset) begin
        check("reset_amplitude", out_amplitude, 0);
        check("reset_time", out_time, 0);
        check("reset_width", out_width, 0);
      end
    end
    if (!reset) begin
      started    = 1'b1;
      just_reset = 1'b1;
      m_ts       = 0;
      in_pulse   = 1'b0;
      dead_left  = 0;
      p_amp.delete();
      p_ts.delete();
      occ        = 0;
      drops      = 0;
      exp_q.delete();
    end else if (started) begin
      just_reset = 1'b0;
      m_above    = int'(input_data) > int'(threshold);
      m_pop      = (occ > 0) && out_ready;
      m_push     = 1'b0;
      if (dead_left > 0) begin
        dead_left--;
      end else if (in_pulse) begin
        if (m_above) begin
          p_amp.push_back(int'(input_data));
          p_ts.push_back(m_ts);
        end else begin
          m_ev.amp = p_amp[0];
          m_ev.t   = p_ts[0];
          for (int i = 1; i < p_amp.size(); i++)
            if (p_amp[i] > m_ev.amp) begin
              m_ev.amp = p_amp[i];
              m_ev.t   = p_ts[i];
            end
          m_ev.w    = (p_amp.size() > WMAX) ? WMAX : p_amp.size();
          m_push    = 1'b1;
          in_pulse  = 1'b0;
          dead_left = HOLD;
        end
      end else if (m_above) begin
        in_pulse = 1'b1;
        p_amp.delete();
        p_ts.delete();
        p_amp.push_back(int'(input_data));
        p_ts.push_back(m_ts);
      end
      if (m_push) begin
        if (occ == DEPTH && !m_pop) begin
          if (drops < 65535) drops++;
        end else begin
          exp_q.push_back(m_ev);
          occ++;
        end
      end
      if (m_pop) occ--;
      m_ts = (m_ts + 1) % TS_MOD;
    end
  end

  // Monitor: every transfer must match the oldest expected event.
  bit                       stall_prev = 1'b0;
  logic signed [DATA_W-1:0] hold_amp;
  logic [TS_W-1:0]          hold_time;
  logic [WIDTH_W-1:0]       hold_width;
  ev_t                      mon_ev;

  always @(negedge clk) begin
    if (done) begin
      check("queue_drained", exp_q.size(), 0);
      done = 1'b0;
    end
    if (started && reset) begin
      if (stall_prev && out_valid) begin
        check("hold_amplitude", out_amplitude, hold_amp);
        check("hold_time", out_time, hold_time);
        check("hold_width", out_width, hold_width);
      end
      stall_prev = out_valid && !out_ready;
      hold_amp   = out_amplitude;
      hold_time  = out_time;
      hold_width = out_width;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got amp=%0d time=%0d width=%0d expected none",
                   out_amplitude, out_time, out_width);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_amplitude", out_amplitude, mon_ev.amp);
          check("event_time", out_time, mon_ev.t);
          check("event_width", out_width, mon_ev.w);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step(input int d);
    input_data = DATA_W'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int level);
    for (int i = 0; i < n; i++) step(level);
  endtask

  task automatic pulse(input int amp);
    step(amp);
    step(0);
    idle(HOLD + 2, 0);
  endtask

  initial begin
    reset = 1'b0;
    threshold = DATA_W'(100);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;

    // Single pulse at timestamps 10..15.
    idle(10, 0);
    step(0); step(0); step(150); step(300); step(250); step(50);
    idle(HOLD + 4, 0);

    // Tie keeps first sample; re-crossing during holdoff is ignored.
    step(200); step(200); step(0); step(0); step(200); step(0);
    idle(HOLD + 4, 0);

    // Backpressure: six pulses into a four-deep FIFO, then drain.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) pulse(110 + 10 * k);
    out_ready = 1'b1;
    idle(8, 0);

    // Push and pop on the same edge while full.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) pulse(400 + k);
    step(777);
    out_ready = 1'b1;
    step(0);
    idle(HOLD + 6, 0);

    // Negative threshold.
    threshold = DATA_W'(-50);
    step(-100); step(-10); step(-100);
    idle(HOLD + 3, -100);
    threshold = DATA_W'(100);

    // Width saturation.
    idle(300, 500);
    step(0);
    idle(HOLD + 3, 0);

    // Randomized traffic with timestamp wrap, threshold changes and stalls.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 63) == 0) threshold = DATA_W'(int'($urandom_range(0, 150)) - 50);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) step(int'($urandom_range(0, 4)) * 50 - 60);
      else                           step(int'(input_data));
    end
    out_ready = 1'b1;
    threshold = DATA_W'(100);
    idle(20, 0);

    // Reset mid-pulse with two events queued.
    out_ready = 1'b0;
    pulse(210);
    pulse(220);
    step(200); step(300);
    reset = 1'b0;
    step(0); step(0);
    reset = 1'b1;
    out_ready = 1'b1;
    idle(20, 0);

    done = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
